fp_convert_round: RTL and testbench

FP_CONVERT_ROUND -- requirements
Module: fp_convert_round

---
 rtl/fp_convert_round_pkg.sv | 18 +
 rtl/fp_round_stage.sv | 39 +++
 rtl/fp_convert_round.sv | 161 ++++++++++++++++
 tb/tb_fp_convert_round.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_convert_round_pkg.sv
// Shared types and constants for the integer-to-float conversion block.
package fp_convert_round_pkg;

  localparam int unsigned STATE_W = 2;

  // Conversion sequencer states
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Round-mode encodings as seen on round_mode
  localparam logic RND_HALF_UP = 1'b0;
  localparam logic RND_TRUNC   = 1'b1;

endpackage : fp_convert_round_pkg

// File: rtl/fp_round_stage.sv
// Combinational rounding, mantissa carry and exponent saturation for one sample.
module fp_round_stage
  import fp_convert_round_pkg::*;
#(
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned MANT_W = 4
) (
  input  logic [MANT_W-1:0] mag_i,
  input  logic              rbit_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic              mode_i,
  input  logic              sat_i,
  output logic [EXP_W-1:0]  exp_c_o,
  output logic [MANT_W-1:0] mant_c_o
);

  localparam int unsigned SUM_W = MANT_W + 1;

  logic [SUM_W-1:0] sum_c;
  logic             inc_c;
  logic             carry_c;

  // Add the round bit in half-up mode, then fold a carry-out into the exponent
  always_comb begin
    inc_c    = (mode_i == RND_HALF_UP) && rbit_i;
    sum_c    = {1'b0, mag_i} + SUM_W'(inc_c);
    carry_c  = sum_c[MANT_W];
    exp_c_o  = exp_i;
    mant_c_o = sum_c[MANT_W-1:0];
    if (sat_i || (carry_c && (&exp_i))) begin
      exp_c_o  = {EXP_W{1'b1}};
      mant_c_o = {MANT_W{1'b1}};
    end else if (carry_c) begin
      exp_c_o  = exp_i + EXP_W'(1);
      mant_c_o = {1'b1, {(MANT_W-1){1'b0}}};
    end
  end

endmodule : fp_round_stage

// File: rtl/fp_convert_round.sv
// Converts a signed integer sample to sign/exponent/mantissa form by
// iterative right shifts, then rounds (half-up or truncate) with saturation.
module fp_convert_round
  import fp_convert_round_pkg::*;
#(
  parameter int unsigned IN_W   = 12,
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned MANT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              round_mode,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [IN_W-1:0]     mag_q, mag_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                rbit_q, rbit_d;
  logic                mode_q, mode_d;
  logic                sat_q, sat_d;
  logic                out_sign_q, out_sign_d;
  logic [EXP_W-1:0]    out_exp_q, out_exp_d;
  logic [MANT_W-1:0]   out_mant_q, out_mant_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;

  logic [IN_W-1:0]     abs_c;
  logic                mag_big_c;
  logic [EXP_W-1:0]    rnd_exp_c;
  logic [MANT_W-1:0]   rnd_mant_c;

  // Rounding datapath; only the low MANT_W magnitude bits matter once
  // normalisation is done, and saturation overrides everything otherwise
  fp_round_stage #(
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W)
  ) u_round (
    .mag_i    (mag_q[MANT_W-1:0]),
    .rbit_i   (rbit_q),
    .exp_i    (exp_q),
    .mode_i   (mode_q),
    .sat_i    (sat_q),
    .exp_c_o  (rnd_exp_c),
    .mant_c_o (rnd_mant_c)
  );

  // Magnitude of the incoming sample; the most-negative value maps to 2^(IN_W-1)
  always_comb begin
    abs_c = in_data;
    if (in_data[IN_W-1]) begin
      abs_c = (~in_data) + IN_W'(1);
    end
  end

  // Next-state and next-output logic for the conversion sequencer
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    rbit_d     = rbit_q;
    mode_d     = mode_q;
    sat_d      = sat_q;
    out_sign_d = out_sign_q;
    out_exp_d  = out_exp_q;
    out_mant_d = out_mant_q;
    mag_big_c  = |mag_q[IN_W-1:MANT_W];

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_data[IN_W-1];
          mag_d   = abs_c;
          exp_d   = '0;
          rbit_d  = 1'b0;
          mode_d  = round_mode;
          sat_d   = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_big_c) begin
          if (&exp_q) begin
            sat_d   = 1'b1;
            state_d = ROUND;
          end else begin
            mag_d  = mag_q >> 1;
            rbit_d = mag_q[0];
            exp_d  = exp_q + EXP_W'(1);
          end
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        out_sign_d = sign_q;
        out_exp_d  = rnd_exp_c;
        out_mant_d = rnd_mant_c;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      rbit_q      <= 1'b0;
      mode_q      <= RND_HALF_UP;
      sat_q       <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_mant_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      rbit_q      <= rbit_d;
      mode_q      <= mode_d;
      sat_q       <= sat_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_mant_q  <= out_mant_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_mant  = out_mant_q;

endmodule : fp_convert_round

// File: tb/tb_fp_convert_round.sv
// Directed and randomized checks of fp_convert_round against an arithmetic reference.
module tb_fp_convert_round;

  localparam int unsigned IN_W   = 12;
  localparam int unsigned EXP_W  = 3;
  localparam int unsigned MANT_W = 4;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam int MMAX = (1 << MANT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic              round_mode;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_mant;
  logic              out_valid;
  logic              out_ready;

  int n_cmp;
  int n_err;

  fp_convert_round #(
    .IN_W   (IN_W),
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .round_mode (round_mode),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_mant   (out_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: smallest shift bringing |x| below 2^MANT_W (capped), then round
  function automatic void ref_conv(input logic [IN_W-1:0] d, input bit mode,
                                   output int s, output int e, output int m,
                                   output int lat);
    int v, mag, sh, r, q;
    bit sat;
    v   = int'($signed(d));
    s   = (v < 0) ? 1 : 0;
    mag = (v < 0) ? -v : v;
    sh  = 0;
    while (sh < EMAX && (mag >> sh) >= (1 << MANT_W)) sh++;
    sat = ((mag >> sh) >= (1 << MANT_W));
    r   = (sh > 0) ? ((mag >> (sh - 1)) & 1) : 0;
    q   = (mag >> sh) + ((mode == 1'b0) ? r : 0);
    lat = sh + 2;
    if (sat) begin
      e = EMAX; m = MMAX;
    end else if (q == (1 << MANT_W)) begin
      if (sh == EMAX) begin
        e = EMAX; m = MMAX;
      end else begin
        e = sh + 1; m = 1 << (MANT_W - 1);
      end
    end else begin
      e = sh; m = q;
    end
  endfunction

  // Present one sample (called #1 after an edge, DUT idle); returns result and latency
  task automatic run(input logic [IN_W-1:0] d, input bit mode,
                     output int s, output int e, output int m, output int lat);
    in_data    = d;
    round_mode = mode;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    do begin
      in_valid   = 1'($urandom);
      in_data    = IN_W'($urandom);
      round_mode = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    chk("out_valid_seen", int'(out_valid), 1);
    s = int'(out_sign);
    e = int'(out_exp);
    m = int'(out_mant);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(out_valid), 0);
    chk({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  task automatic directed(input string tag, input logic [IN_W-1:0] d, input bit mode,
                          input int es, input int ee, input int em, input int el);
    int s, e, m, lat;
    run(d, mode, s, e, m, lat);
    chk({tag, "_sign"}, s, es);
    chk({tag, "_exp"}, e, ee);
    chk({tag, "_mant"}, m, em);
    if (el >= 0) chk({tag, "_lat"}, lat, el);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, m, lat, rs, re, rm, rl;
    logic [IN_W-1:0] d;
    bit mode;
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    round_mode = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_fields", int'({out_sign, out_exp, out_mant}), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Known vectors
    directed("p422", 12'd422, 1'b0, 0, 5, 13, 7);
    directed("n422", 12'hE5A, 1'b0, 1, 5, 13, 7);
    directed("c125_hu", 12'd125, 1'b0, 0, 4, 8, 5);
    directed("c125_tr", 12'd125, 1'b1, 0, 3, 15, 5);
    directed("neg_max", 12'h800, 1'b0, 1, 7, 15, 9);
    directed("pos_max", 12'h7FF, 1'b0, 0, 7, 15, 9);
    directed("zero", 12'd0, 1'b0, 0, 0, 0, 2);

    // Output stall: fields hold and new requests are ignored
    run(12'd422, 1'b0, s, e, m, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = IN_W'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_fields", int'({out_sign, out_exp, out_mant}), (5 << MANT_W) | 13);
    end
    in_valid = 1'b0;
    handshake("stall");

    // Reset in the middle of normalisation
    in_data  = 12'd2047;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_fields", int'({out_sign, out_exp, out_mant}), 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("post_rst_no_result", int'(out_valid), 0);
    end
    directed("after_rst", 12'd5, 1'b0, 0, 0, 5, 2);

    // Randomized samples against the reference
    for (int i = 0; i < 60; i++) begin
      d    = IN_W'($urandom);
      mode = 1'($urandom);
      ref_conv(d, mode, rs, re, rm, rl);
      run(d, mode, s, e, m, lat);
      chk("rnd_sign", s, rs);
      chk("rnd_exp", e, re);
      chk("rnd_mant", m, rm);
      chk("rnd_lat", lat, rl);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      handshake("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fp_convert_round
